cache_miss_handler: RTL



---
 rtl/cache_pkg.sv | 48 ++++
 rtl/cache_miss_handler_if.sv | 77 +++++++
 rtl/cache_beat_counter.sv | 40 ++++
 rtl/cache_miss_handler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared geometry, types and helpers for the cache miss-service slice.
//   - Line geometry: line size, beat width, tag/index/way widths
//   - Derived widths: OFFSET_BITS, WAY_BITS, BEATS, BEAT_BITS
//   - state_e: miss-handler FSM states
//   - line_addr(): line-aligned memory address {tag, index, offset zeros}
// ----------------------------------------------------------------------------
package cache_pkg;

   localparam int LINE_SIZE_BYTES = 64;
   localparam int DATA_WIDTH      = 32;
   localparam int TAG_BITS        = 18;
   localparam int INDEX_BITS      = 8;
   localparam int WAYS            = 4;
   localparam int ADDR_WIDTH      = 32;

   localparam int OFFSET_BITS = $clog2(LINE_SIZE_BYTES);
   localparam int WAY_BITS    = $clog2(WAYS);
   localparam int BEATS       = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
   localparam int BEAT_BITS   = $clog2(BEATS);

   // The address is exactly tag, set and byte offset; line_addr() relies on it.
   localparam bit ADDR_SPLIT_OK = (ADDR_WIDTH == TAG_BITS + INDEX_BITS + OFFSET_BITS);

   typedef logic [TAG_BITS-1:0]   tag_t;
   typedef logic [INDEX_BITS-1:0] index_t;
   typedef logic [WAY_BITS-1:0]   way_t;
   typedef logic [BEAT_BITS-1:0]  beat_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WB_REQ  = 3'd1,
      ST_WB_RD   = 3'd2,
      ST_WB_SEND = 3'd3,
      ST_RF_REQ  = 3'd4,
      ST_RF_DATA = 3'd5,
      ST_META    = 3'd6
   } state_e;

   // Line-aligned byte address of a cache line.
   function automatic addr_t line_addr(input tag_t tag, input index_t index);
      return {tag, index, {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/cache_miss_handler_if.sv
// ----------------------------------------------------------------------------
// cache_miss_handler_if
// Bundles the three buses of the miss handler:
//   - miss request from the lookup stage (valid/ready plus victim info)
//   - data/metadata array access (read strobe, write strobe, way/set/beat)
//   - main-memory burst channel (request, writeback beats, refill beats)
// Modports:
//   master : the miss handler itself
//   slave  : the environment (lookup stage, array and memory)
// ----------------------------------------------------------------------------
interface cache_miss_handler_if;
   import cache_pkg::*;

   // Miss request
   logic   i_miss_valid;
   logic   o_miss_ready;
   tag_t   i_miss_tag;
   index_t i_miss_index;
   way_t   i_victim_way;
   logic   i_victim_dirty;
   tag_t   i_victim_tag;

   // Array access
   logic   o_arr_rd_en;
   way_t   o_arr_way;
   index_t o_arr_index;
   beat_t  o_arr_beat;
   data_t  i_arr_rd_data;
   logic   o_arr_wr_en;
   data_t  o_arr_wr_data;
   logic   o_meta_wr_en;
   tag_t   o_meta_tag;

   // Memory burst channel
   logic   o_mem_req_valid;
   logic   i_mem_req_ready;
   logic   o_mem_req_we;
   addr_t  o_mem_req_addr;
   logic   o_mem_wvalid;
   logic   i_mem_wready;
   data_t  o_mem_wdata;
   logic   i_mem_rvalid;
   data_t  i_mem_rdata;

   logic   o_done;

   modport master (
      input  i_miss_valid, i_miss_tag, i_miss_index, i_victim_way,
             i_victim_dirty, i_victim_tag,
      output o_miss_ready,
      output o_arr_rd_en, o_arr_way, o_arr_index, o_arr_beat,
      input  i_arr_rd_data,
      output o_arr_wr_en, o_arr_wr_data, o_meta_wr_en, o_meta_tag,
      output o_mem_req_valid, o_mem_req_we, o_mem_req_addr,
      input  i_mem_req_ready,
      output o_mem_wvalid, o_mem_wdata,
      input  i_mem_wready,
      input  i_mem_rvalid, i_mem_rdata,
      output o_done
   );

   modport slave (
      output i_miss_valid, i_miss_tag, i_miss_index, i_victim_way,
             i_victim_dirty, i_victim_tag,
      input  o_miss_ready,
      input  o_arr_rd_en, o_arr_way, o_arr_index, o_arr_beat,
      output i_arr_rd_data,
      input  o_arr_wr_en, o_arr_wr_data, o_meta_wr_en, o_meta_tag,
      input  o_mem_req_valid, o_mem_req_we, o_mem_req_addr,
      output i_mem_req_ready,
      input  o_mem_wvalid, o_mem_wdata,
      output i_mem_wready,
      output i_mem_rvalid, i_mem_rdata,
      input  o_done
   );

endinterface

// File: rtl/cache_beat_counter.sv
// ----------------------------------------------------------------------------
// cache_beat_counter
// Beat index within a cache line, shared by the writeback and refill phases.
// Wraps BEATS-1 -> 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to 0 (has priority over inc)
//   inc        : advance one beat
//   beat       : current beat index
//   last       : current beat is BEATS-1
// ----------------------------------------------------------------------------
module cache_beat_counter
   import cache_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  inc,
   output beat_t beat,
   output logic  last
);

   beat_t beat_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
      end else if (clr) begin
         beat_q <= '0;
      end else if (inc) begin
         beat_q <= beat_q + 1'b1;   // BEATS is a power of two, so this wraps
      end
   end

   assign beat = beat_q;
   assign last = (beat_q == beat_t'(BEATS - 1));

endmodule

// File: rtl/cache_miss_handler.sv
// ----------------------------------------------------------------------------
// cache_miss_handler
// Services one cache miss at a time: optionally writes the dirty victim line
// back to memory, refills the line beat by beat into the data array, then
// writes tag/valid/dirty metadata and pulses o_done so the lookup can replay.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (aborts any miss)
//   bus        : miss request, array access and memory channel (master view)
// ----------------------------------------------------------------------------
module cache_miss_handler
   import cache_pkg::*;
(
   input logic                   clk,
   input logic                   rst_n,
   cache_miss_handler_if.master  bus
);

   state_e state_q, state_d;

   // Miss context captured at acceptance. The victim dirty bit only steers the
   // first transition, so it is consumed directly and not stored.
   tag_t   tag_q;
   index_t index_q;
   way_t   way_q;
   tag_t   vtag_q;

   // Writeback beat data. The array returns data the cycle after o_arr_rd_en,
   // i.e. in the first WB_SEND cycle; it is forwarded that cycle and held from
   // the register afterwards, giving a 2-cycle-per-beat minimum.
   data_t  wdata_q;
   logic   wfirst_q;

   logic   capture;
   logic   cnt_clr;
   logic   cnt_inc;
   beat_t  beat;
   logic   beat_last;

   cache_beat_counter u_beat_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .beat  (beat),
      .last  (beat_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         tag_q    <= '0;
         index_q  <= '0;
         way_q    <= '0;
         vtag_q   <= '0;
         wdata_q  <= '0;
         wfirst_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wfirst_q <= (state_q == ST_WB_RD);
         if (capture) begin
            tag_q   <= bus.i_miss_tag;
            index_q <= bus.i_miss_index;
            way_q   <= bus.i_victim_way;
            vtag_q  <= bus.i_victim_tag;
         end
         if (wfirst_q) begin
            wdata_q <= bus.i_arr_rd_data;
         end
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skips an assignment would otherwise infer a latch.
      state_d             = state_q;
      capture             = 1'b0;
      cnt_clr             = 1'b0;
      cnt_inc             = 1'b0;
      bus.o_miss_ready    = 1'b0;
      bus.o_arr_rd_en     = 1'b0;
      bus.o_arr_wr_en     = 1'b0;
      bus.o_arr_wr_data   = '0;
      bus.o_meta_wr_en    = 1'b0;
      bus.o_mem_req_valid = 1'b0;
      bus.o_mem_req_we    = 1'b0;
      bus.o_mem_req_addr  = '0;
      bus.o_mem_wvalid    = 1'b0;
      bus.o_mem_wdata     = '0;
      bus.o_done          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus.o_miss_ready = 1'b1;
            if (bus.i_miss_valid) begin
               capture = 1'b1;
               cnt_clr = 1'b1;
               state_d = bus.i_victim_dirty ? ST_WB_REQ : ST_RF_REQ;
            end
         end

         ST_WB_REQ: begin
            bus.o_mem_req_valid = 1'b1;
            bus.o_mem_req_we    = 1'b1;
            bus.o_mem_req_addr  = line_addr(vtag_q, index_q);
            if (bus.i_mem_req_ready) begin
               state_d = ST_WB_RD;
            end
         end

         ST_WB_RD: begin
            bus.o_arr_rd_en = 1'b1;
            state_d         = ST_WB_SEND;
         end

         ST_WB_SEND: begin
            bus.o_mem_wvalid = 1'b1;
            bus.o_mem_wdata  = wfirst_q ? bus.i_arr_rd_data : wdata_q;
            if (bus.i_mem_wready) begin
               cnt_inc = 1'b1;   // wraps to 0 after the last beat
               state_d = beat_last ? ST_RF_REQ : ST_WB_RD;
            end
         end

         ST_RF_REQ: begin
            bus.o_mem_req_valid = 1'b1;
            bus.o_mem_req_we    = 1'b0;
            bus.o_mem_req_addr  = line_addr(tag_q, index_q);
            if (bus.i_mem_req_ready) begin
               cnt_clr = 1'b1;
               state_d = ST_RF_DATA;
            end
         end

         ST_RF_DATA: begin
            // Refill beats have no backpressure: each one is written the
            // cycle it arrives.
            if (bus.i_mem_rvalid) begin
               bus.o_arr_wr_en   = 1'b1;
               bus.o_arr_wr_data = bus.i_mem_rdata;
               cnt_inc           = 1'b1;
               if (beat_last) begin
                  state_d = ST_META;
               end
            end
         end

         ST_META: begin
            bus.o_meta_wr_en = 1'b1;
            bus.o_done       = 1'b1;
            state_d          = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Array addressing follows the captured miss whenever a miss is in flight.
   assign bus.o_arr_way   = (state_q == ST_IDLE) ? '0 : way_q;
   assign bus.o_arr_index = (state_q == ST_IDLE) ? '0 : index_q;
   assign bus.o_arr_beat  = beat;
   assign bus.o_meta_tag  = tag_q;

endmodule
